trash_fetch_unit: RTL and testbench

//  Front end for the trash CPU. Loads a program from the 8-bit pin bus as a byte stream into a

---
 rtl/trash_pkg.sv | 24 ++
 rtl/trash_prog_store.sv | 40 ++++
 rtl/trash_fetch_unit.sv | 208 ++++++++++++++++++++
 tb/tb_trash_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/trash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trash_pkg
// Description : Shared types and constants for the trash CPU fetch front end.
//               fetch_state_t - fetch FSM state encoding
//               instr_word_t  - 16-bit instruction word
//               TRASH_BYTE_W  - width of the program load bus
// Revision    : 1.0 - initial release
// ============================================================================
package trash_pkg;

    localparam int TRASH_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FETCH = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    typedef logic [15:0] instr_word_t;

endpackage : trash_pkg
`default_nettype wire

// File: rtl/trash_prog_store.sv
`default_nettype none
// ============================================================================
// Module      : trash_prog_store
// Description : DEPTH x 16-bit flop-based program store. One synchronous
//               write port, one asynchronous read port. Contents are not
//               reset.
// Ports       : clk    in   clock
//               we     in   write enable
//               waddr  in   write word address
//               wdata  in   write word
//               raddr  in   read word address
//               rdata  out  word at raddr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module trash_prog_store
    import trash_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  instr_word_t   wdata,
    input  logic [AW-1:0] raddr,
    output instr_word_t   rdata
);

    instr_word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : trash_prog_store
`default_nettype wire

// File: rtl/trash_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : trash_fetch_unit
// Description : Trash CPU front end. Packs a byte stream from the pin bus
//               into 16-bit words in the program store (LOAD), then streams
//               words to the execution stage over valid/ready (FETCH),
//               following jump redirects and halting on a bad target or an
//               empty program.
// Ports       : clk, reset (sync, active-high)
//               load_mode, load_valid, load_byte   - program load bus
//               run                                - fetch enable (level)
//               instr_valid/instr_ready/instr/instr_pc - instruction stream
//               redirect_valid, redirect_addr      - jump from execution
//               prog_len, halted, odd_drop         - status
//               cksum                              - XOR of loaded bytes
// Config      : TRASH_LOAD_CKSUM_EN - when defined, adds the cksum port and
//               its register; otherwise both are absent.
// Revision    : 1.0 - initial release
// ============================================================================
module trash_fetch_unit
    import trash_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_mode,
    input  logic                    load_valid,
    input  logic [TRASH_BYTE_W-1:0] load_byte,
    input  logic                    run,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output instr_word_t             instr,
    output logic [AW-1:0]           instr_pc,
    input  logic                    redirect_valid,
    input  logic [AW-1:0]           redirect_addr,
    output logic [AW:0]             prog_len,
    output logic                    halted,
    output logic                    odd_drop
`ifdef TRASH_LOAD_CKSUM_EN
    ,
    output logic [TRASH_BYTE_W-1:0] cksum
`endif
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_HALT  = HALT;

    localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);

    logic [1:0]              state;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           pc;
    logic                    phase;      // 0 = expecting low byte
    logic [TRASH_BYTE_W-1:0] lo_byte;

    logic                    enter_load;
    logic                    byte_accept;
    logic                    mem_we;
    logic                    handshake;
    logic                    redirect_ok;
    logic [AW:0]             pc_plus;
    logic [AW-1:0]           pc_inc;
    logic [AW-1:0]           rd_addr;
    instr_word_t             rd_data;

    assign enter_load  = load_mode && (state != ST_LOAD);
    assign byte_accept = (state == ST_LOAD) && load_valid;
    assign mem_we      = byte_accept && phase;
    assign handshake   = instr_valid && instr_ready;
    assign redirect_ok = ({1'b0, redirect_addr} < prog_len);

    // Sequential successor wraps back to word 0 after the last loaded word,
    // not after DEPTH-1, so short programs loop on themselves.
    assign pc_plus = {1'b0, pc} + 1'b1;
    assign pc_inc  = (pc_plus == prog_len) ? '0 : pc_plus[AW-1:0];

    // Single read port: the address is whatever word will be presented
    // next. Redirect wins over the sequential step.
    always_comb begin
        rd_addr = pc;
        if (redirect_valid) begin
            rd_addr = redirect_addr;
        end else if (handshake) begin
            rd_addr = pc_inc;
        end
    end

    trash_prog_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata ({load_byte, lo_byte}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            prog_len    <= '0;
            halted      <= 1'b0;
            odd_drop    <= 1'b0;
            wr_ptr      <= '0;
            phase       <= 1'b0;
            lo_byte     <= '0;
            pc          <= '0;
        end else if (enter_load) begin
            // load_mode outranks everything outside LOAD
            state       <= ST_LOAD;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            wr_ptr      <= '0;
            prog_len    <= '0;
            phase       <= 1'b0;
            odd_drop    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        if (prog_len != '0) begin
                            state <= ST_FETCH;
                            pc    <= '0;
                        end else begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (load_valid) begin
                        phase <= ~phase;
                        if (!phase) begin
                            lo_byte <= load_byte;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (prog_len != LEN_FULL) begin
                                prog_len <= prog_len + 1'b1;
                            end
                        end
                    end
                    if (!load_mode) begin
                        state <= ST_IDLE;
                        // A byte accepted on the exit cycle still counts
                        // toward the pairing.
                        odd_drop <= phase ^ load_valid;
                    end
                end

                ST_FETCH: begin
                    if (redirect_valid) begin
                        if (redirect_ok) begin
                            instr       <= rd_data;
                            instr_pc    <= redirect_addr;
                            pc          <= redirect_addr;
                            instr_valid <= 1'b1;
                        end else begin
                            state       <= ST_HALT;
                            halted      <= 1'b1;
                            instr_valid <= 1'b0;
                        end
                    end else if (!instr_valid || handshake) begin
                        if (!run) begin
                            // Outstanding word has been taken; stop here.
                            state       <= ST_IDLE;
                            instr_valid <= 1'b0;
                        end else begin
                            instr       <= rd_data;
                            instr_pc    <= rd_addr;
                            pc          <= rd_addr;
                            instr_valid <= 1'b1;
                        end
                    end
                end

                ST_HALT: begin
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TRASH_LOAD_CKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || enter_load) begin
            cksum <= '0;
        end else if (byte_accept) begin
            cksum <= cksum ^ load_byte;
        end
    end
`endif

endmodule : trash_fetch_unit
`default_nettype wire

// File: tb/tb_trash_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_trash_fetch_unit
// Description : Directed self-checking bench for trash_fetch_unit (DEPTH=8).
//               Scenarios: reset, basic stream with wrap, odd byte drop,
//               store overflow, backpressure, redirect, empty program and
//               load during fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trash_fetch_unit;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_mode;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          run;
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic [AW:0]   prog_len;
    logic          halted;
    logic          odd_drop;
`ifdef TRASH_LOAD_CKSUM_EN
    logic [7:0]    cksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] lb [32];

    always #5 clk = ~clk;

    trash_fetch_unit #(
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_mode      (load_mode),
        .load_valid     (load_valid),
        .load_byte      (load_byte),
        .run            (run),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .prog_len       (prog_len),
        .halted         (halted),
        .odd_drop       (odd_drop)
`ifdef TRASH_LOAD_CKSUM_EN
        ,
        .cksum          (cksum)
`endif
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Enter LOAD, stream lb[0..n-1] one byte per cycle, leave LOAD.
    task automatic load_seq(input int n);
        load_mode = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_byte  = lb[i];
            tick();
        end
        load_valid = 1'b0;
        load_mode  = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", instr); end
        n_checks++; if (instr_pc !== 3'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", instr_pc); end
        n_checks++; if (prog_len !== 4'd0) begin n_fail++; $display("FAIL reset_len: got %0d expected 0", prog_len); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_checks++; if (odd_drop !== 1'b0) begin n_fail++; $display("FAIL reset_odd: got %b expected 0", odd_drop); end
`ifdef TRASH_LOAD_CKSUM_EN
        n_checks++; if (cksum !== 8'h00) begin n_fail++; $display("FAIL reset_cksum: got %h expected 00", cksum); end
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        lb[0] = 8'h34; lb[1] = 8'h12; lb[2] = 8'h78; lb[3] = 8'h56;
        load_seq(4);
        n_checks++; if (prog_len !== 4'd2) begin n_fail++; $display("FAIL basic_len: got %0d expected 2", prog_len); end
        run = 1'b1; instr_ready = 1'b1;
        tick(2);
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 3'd0) begin n_fail++; $display("FAIL basic_w0: got v=%b %h pc%0d expected v=1 1234 pc0", instr_valid, instr, instr_pc); end
        tick();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'h5678 || instr_pc !== 3'd1) begin n_fail++; $display("FAIL basic_w1: got v=%b %h pc%0d expected v=1 5678 pc1", instr_valid, instr, instr_pc); end
        tick();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 3'd0) begin n_fail++; $display("FAIL basic_wrap: got v=%b %h pc%0d expected v=1 1234 pc0", instr_valid, instr, instr_pc); end
        run = 1'b0;
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_stop: got %b expected 0", instr_valid); end
        instr_ready = 1'b0;
        tick();
    endtask

    task automatic test_odd_drop;
        lb[0] = 8'hAA; lb[1] = 8'hBB; lb[2] = 8'hCC;
        load_seq(3);
        n_checks++; if (prog_len !== 4'd1) begin n_fail++; $display("FAIL odd_len: got %0d expected 1", prog_len); end
        n_checks++; if (odd_drop !== 1'b1) begin n_fail++; $display("FAIL odd_flag: got %b expected 1", odd_drop); end
`ifdef TRASH_LOAD_CKSUM_EN
        n_checks++; if (cksum !== 8'hDD) begin n_fail++; $display("FAIL odd_cksum: got %h expected DD", cksum); end
`endif
    endtask

    // Nine words into an eight-word store: word 8 overwrites word 0.
    // Word i = {B0+i, 10+i}. Continues into the backpressure scenario.
    task automatic test_overflow_and_stall;
        for (int i = 0; i < 9; i++) begin
            lb[2*i]   = 8'h10 + 8'(i);
            lb[2*i+1] = 8'hB0 + 8'(i);
        end
        load_seq(18);
        n_checks++; if (prog_len !== 4'd8) begin n_fail++; $display("FAIL ovf_len: got %0d expected 8", prog_len); end
        n_checks++; if (odd_drop !== 1'b0) begin n_fail++; $display("FAIL ovf_odd_cleared: got %b expected 0", odd_drop); end
        run = 1'b1; instr_ready = 1'b1;
        tick(2);
        n_checks++; if (instr !== 16'hB818 || instr_pc !== 3'd0) begin n_fail++; $display("FAIL ovf_w8: got %h pc%0d expected B818 pc0", instr, instr_pc); end
        tick();
        n_checks++; if (instr !== 16'hB111 || instr_pc !== 3'd1) begin n_fail++; $display("FAIL ovf_w1: got %h pc%0d expected B111 pc1", instr, instr_pc); end
        instr_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (instr_valid !== 1'b1 || instr !== 16'hB111 || instr_pc !== 3'd1) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b %h pc%0d expected v=1 B111 pc1", c, instr_valid, instr, instr_pc); end
        end
        instr_ready = 1'b1;
        tick();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'hB212 || instr_pc !== 3'd2) begin n_fail++; $display("FAIL stall_release: got v=%b %h pc%0d expected v=1 B212 pc2", instr_valid, instr, instr_pc); end
        run = 1'b0;
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_stop: got %b expected 0", instr_valid); end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect;
        for (int i = 0; i < 4; i++) begin
            lb[2*i]   = 8'hD0 + 8'(i);
            lb[2*i+1] = 8'hC0 + 8'(i);
        end
        load_seq(8);
        run = 1'b1; instr_ready = 1'b1;
        tick(2);
        n_checks++; if (instr !== 16'hC0D0 || instr_pc !== 3'd0) begin n_fail++; $display("FAIL redir_w0: got %h pc%0d expected C0D0 pc0", instr, instr_pc); end
        redirect_valid = 1'b1; redirect_addr = 3'd1;
        tick();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'hC1D1 || instr_pc !== 3'd1) begin n_fail++; $display("FAIL redir_target: got v=%b %h pc%0d expected v=1 C1D1 pc1", instr_valid, instr, instr_pc); end
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (instr !== 16'hC2D2 || instr_pc !== 3'd2) begin n_fail++; $display("FAIL redir_next: got %h pc%0d expected C2D2 pc2", instr, instr_pc); end
        redirect_valid = 1'b1; redirect_addr = 3'd5;
        tick();
        n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bad: got halted=%b v=%b expected halted=1 v=0", halted, instr_valid); end
        redirect_valid = 1'b0;
        tick(2);
        n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_sticky: got halted=%b v=%b expected halted=1 v=0", halted, instr_valid); end
        run = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_empty_and_reload;
        load_seq(0);
        n_checks++; if (halted !== 1'b0 || prog_len !== 4'd0) begin n_fail++; $display("FAIL empty_load: got halted=%b len=%0d expected halted=0 len=0", halted, prog_len); end
        run = 1'b1;
        tick();
        n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL empty_halt: got halted=%b v=%b expected halted=1 v=0", halted, instr_valid); end
        run = 1'b0;
        lb[0] = 8'h01; lb[1] = 8'hE0; lb[2] = 8'h02; lb[3] = 8'hE0;
        load_seq(4);
        n_checks++; if (halted !== 1'b0 || prog_len !== 4'd2) begin n_fail++; $display("FAIL reload: got halted=%b len=%0d expected halted=0 len=2", halted, prog_len); end
        run = 1'b1; instr_ready = 1'b1;
        tick(2);
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'hE001) begin n_fail++; $display("FAIL reload_w0: got v=%b %h expected v=1 E001", instr_valid, instr); end
        load_mode = 1'b1;
        tick();
        n_checks++; if (instr_valid !== 1'b0 || prog_len !== 4'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL load_in_fetch: got v=%b len=%0d halted=%b expected v=0 len=0 halted=0", instr_valid, prog_len, halted); end
        tick(2);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL load_hold_idle: got v=%b expected 0", instr_valid); end
        load_mode = 1'b0; run = 1'b0; instr_ready = 1'b0;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        load_mode      = 1'b0;
        load_valid     = 1'b0;
        load_byte      = 8'h00;
        run            = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;

        test_reset();
        test_basic();
        test_odd_drop();
        test_overflow_and_stall();
        test_redirect();
        test_empty_and_reload();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_trash_fetch_unit
`default_nettype wire
